// File: rtl/uart_pkg.sv
// Shared constants and feeder state encodings for the UART transmit FIFO.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } feed_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO: storage, wrapping pointers and registered count/empty/full.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BYTE_W-1:0] wr_data,
  output logic [BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              do_push;
  logic              do_pop;

  // A flush overrides any push or pop in the same cycle.
  assign do_push = push && !full_q && !flush;
  assign do_pop  = pop && !empty_q && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = empty_q;
  assign full    = full_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter with a start/busy handshake feeder.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_empty,
  output logic              fifo_full
);

  feed_state_e       state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [BYTE_W-1:0] head;
  logic              push;
  logic              pop;

  // Ready depends only on registered fullness, never on a same-cycle pop.
  assign wr_ready = !rst && !fifo_full && !flush;
  assign push     = wr_valid && wr_ready;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_data),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Feeder: one start per byte, then wait for a full busy high/low cycle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !tx_busy && !flush) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_START: state_d = ST_ACK;
      ST_ACK:   if (tx_busy) state_d = ST_WAIT;
      ST_WAIT:  if (!tx_busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks of uart_tx_fifo against a queue-based reference.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CPB    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic             flush = 1'b0;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [ADDR_W:0]  fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  // Behavioural UART transmitter: 10-bit frame, LSB first, CPB clocks per bit.
  logic       x_busy = 1'b0;
  logic       force_busy = 1'b0;
  logic [9:0] frame = 10'h3ff;
  int         bit_i = 0;
  int         cyc = 0;
  logic       bits_q [$];
  logic       tx_line;

  assign tx_busy = x_busy | force_busy;
  assign tx_line = x_busy ? frame[bit_i] : 1'b1;

  always @(posedge clk) begin
    if (!x_busy) begin
      if (tx_start) begin
        frame  <= {1'b1, tx_data, 1'b0};
        bit_i  <= 0;
        cyc    <= 0;
        x_busy <= 1'b1;
      end
    end else begin
      if (cyc == 1) bits_q.push_back(tx_line);
      if (cyc == CPB - 1) begin
        cyc <= 0;
        if (bit_i == 9) x_busy <= 1'b0;
        else bit_i <= bit_i + 1;
      end else begin
        cyc <= cyc + 1;
      end
    end
  end

  // Reference model state
  logic [7:0] q [$];
  logic [7:0] sent_q [$];
  logic [7:0] last_tx = 8'h00;
  int         phase = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         dut_starts = 0;
  bit         accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample pre-edge values, advance, update the model, compare outputs.
  task automatic tick();
    logic       rdy, bsy, exp_rdy, allowed, r_rst, r_val, r_fl;
    logic [7:0] r_dat, e;
    @(negedge clk);
    rdy = wr_ready; bsy = tx_busy;
    r_rst = rst; r_val = wr_valid; r_fl = flush; r_dat = wr_data;
    @(posedge clk);
    #1;
    accepted = 1'b0;
    if (tx_start === 1'b1) dut_starts++;
    if (r_rst) begin
      chk("ready_in_reset", 32'(rdy), 32'd0);
      q.delete();
      phase   = 0;
      last_tx = 8'h00;
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
    end else begin
      exp_rdy = !r_fl && (q.size() < DEPTH);
      chk("wr_ready", 32'(rdy), 32'(exp_rdy));
      allowed = (phase == 0) && (q.size() > 0) && !bsy && !r_fl;
      if (phase == 1 && bsy) phase = 2;
      else if (phase == 2 && !bsy) phase = 0;
      chk("tx_start", 32'(tx_start), 32'(allowed));
      if (allowed) begin
        e = q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e));
        last_tx = e;
        sent_q.push_back(e);
        phase = 1;
      end else begin
        chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
      end
      if (r_fl) q.delete();
      if (exp_rdy && r_val) begin
        q.push_back(r_dat);
        accepted = 1'b1;
      end
    end
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && (q.size() != 0 || tx_busy || phase != 0); i++) tick();
    chk(tag, 32'(i < budget), 32'd1);
  endtask

  initial begin : stim
    logic [7:0] exp_bits [10];
    logic [7:0] in_b [$];
    int s0, base, i;

    // Reset with a write attempt that must be ignored
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    tick(); tick();
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    // Single byte: latency and serial frame
    bits_q.delete();
    wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_valid = 1'b0;
    chk("lat_edge_k", 32'(tx_start), 32'd0);
    tick();
    chk("lat_edge_k1", 32'(tx_start), 32'd1);
    tick();
    chk("start_one_cycle", 32'(tx_start), 32'd0);
    drain("drain_a5", 200);
    exp_bits = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    chk("frame_len", 32'(bits_q.size()), 32'd10);
    for (int k = 0; k < 10 && k < bits_q.size(); k++)
      chk($sformatf("frame_bit%0d", k), 32'(bits_q[k]), 32'(exp_bits[k][0]));

    // Three back-to-back bytes
    s0 = dut_starts; base = sent_q.size();
    for (int k = 1; k <= 3; k++) begin
      wr_valid = 1'b1; wr_data = 8'(k);
      tick();
    end
    wr_valid = 1'b0;
    drain("drain_three", 600);
    chk("three_starts", 32'(dut_starts - s0), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("three_order", 32'(sent_q[base + k]), 32'(k + 1));

    // Fill with busy held high: 16 accepted, 17th waits for a pop
    force_busy = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h40 + k);
      tick();
    end
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_not_ready", 32'(wr_ready), 32'd0);
    tick(); tick();
    force_busy = 1'b0;
    for (i = 0; i < 20 && !accepted; i++) tick();
    chk("byte17_accepted", 32'(accepted), 32'd1);
    wr_valid = 1'b0;
    drain("drain_full", 2000);

    // Flush with 5 queued and one in flight
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h90 + k);
      tick();
    end
    wr_valid = 1'b0;
    chk("pre_flush_count", 32'(fifo_count), 32'd5);
    s0 = dut_starts;
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_count", 32'(fifo_count), 32'd0);
    drain("drain_flush", 200);
    for (int k = 0; k < 10; k++) tick();
    chk("flush_no_start", 32'(dut_starts - s0), 32'd0);

    // Reset while waiting on busy with 3 queued
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_data = 8'(8'hC0 + k);
      tick();
    end
    wr_valid = 1'b0;
    for (i = 0; i < 20 && phase != 2; i++) tick();
    tick(); tick();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_count", 32'(fifo_count), 32'd0);
    wr_valid = 1'b1; wr_data = 8'h5C;
    tick();
    wr_valid = 1'b0;
    drain("drain_after_rst", 300);
    chk("after_rst_byte", 32'(sent_q[sent_q.size() - 1]), 32'h5C);

    // Sustained random traffic across pointer wrap
    base = sent_q.size();
    for (int k = 0; k < 40; k++) begin
      int gap;
      logic [7:0] b;
      gap = $urandom_range(0, 2);
      b = 8'($urandom);
      in_b.push_back(b);
      wr_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      wr_valid = 1'b1; wr_data = b;
      accepted = 1'b0;
      for (i = 0; i < 200 && !accepted; i++) tick();
      chk("rand_push", 32'(accepted), 32'd1);
    end
    wr_valid = 1'b0;
    drain("drain_rand", 4000);
    chk("rand_len", 32'(sent_q.size() - base), 32'd40);
    for (int k = 0; k < 40 && base + k < sent_q.size(); k++)
      chk("rand_byte", 32'(sent_q[base + k]), 32'(in_b[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
